// File: rtl/decode_stage.sv
// Registered RV32I decode stage with ready/valid handshake on both sides.
// A per-register pending scoreboard stalls read-after-write hazards until writeback.
module decode_stage #(
  parameter  int XLEN    = 32,
  parameter  int NREGS   = 32,
  parameter  int ALUOP_W = 6,
  localparam int RW      = $clog2(NREGS)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               iValid,
  output logic               iReady,
  input  logic [31:0]        idata,
  input  logic [XLEN-1:0]    iPc,
  input  logic               flush,
  input  logic               wbEn,
  input  logic [RW-1:0]      wbRd,
  output logic               dValid,
  input  logic               dReady,
  output logic [XLEN-1:0]    dPc,
  output logic [XLEN-1:0]    imm,
  output logic [ALUOP_W-1:0] aluOp,
  output logic [2:0]         funct3,
  output logic [RW-1:0]      rs1,
  output logic [RW-1:0]      rs2,
  output logic [RW-1:0]      rd,
  output logic               branch,
  output logic               jump,
  output logic               dMEMToReg,
  output logic               memWrite,
  output logic               regOrImm,
  output logic               regWrite,
  output logic               illegal
);
  typedef enum logic [6:0] {
    OP_LUI   = 7'b0110111,
    OP_AUIPC = 7'b0010111,
    OP_JAL   = 7'b1101111,
    OP_JALR  = 7'b1100111,
    OP_BXX   = 7'b1100011,
    OP_LXX   = 7'b0000011,
    OP_SXX   = 7'b0100011,
    OP_IXX   = 7'b0010011,
    OP_RXX   = 7'b0110011
  } opcode_e;

  function automatic logic reg_oob(input logic [4:0] f);
    return 32'(f) >= 32'(NREGS);
  endfunction

  logic [31:0]        w_imm32;
  logic [ALUOP_W-1:0] w_alu;
  logic [2:0]         w_f3;
  logic               w_use_rs1, w_use_rs2, w_use_rd, w_known;
  logic               w_br, w_jmp, w_m2r, w_mw, w_roi;
  logic               w_illegal, w_regwrite, w_hazard, w_accept, w_hs_out;
  logic [RW-1:0]      w_rs1, w_rs2, w_rd;
  logic [NREGS-1:0]   w_pend, w_clr_wb, w_clr_fl, w_set, w_pend_nxt;

  logic [NREGS-1:1]   r_pend;
  logic               r_valid;
  logic [XLEN-1:0]    r_pc, r_imm;
  logic [ALUOP_W-1:0] r_alu;
  logic [2:0]         r_f3;
  logic [RW-1:0]      r_rs1, r_rs2, r_rd;
  logic               r_br, r_jmp, r_m2r, r_mw, r_roi, r_regwrite, r_illegal;

  assign w_f3 = idata[14:12];

  // Opcode decode: field usage, controls, aluOp and 32-bit immediate.
  always_comb begin
    w_imm32   = 32'h0000_0000;
    w_alu     = '0;
    w_use_rs1 = 1'b0;
    w_use_rs2 = 1'b0;
    w_use_rd  = 1'b0;
    w_known   = 1'b1;
    w_br      = 1'b0;
    w_jmp     = 1'b0;
    w_m2r     = 1'b0;
    w_mw      = 1'b0;
    w_roi     = 1'b0;
    case (idata[6:0])
      OP_LUI, OP_AUIPC: begin
        w_use_rd = 1'b1;
        w_roi    = 1'b1;
        w_imm32  = {idata[31:12], 12'h000};
      end
      OP_JAL: begin
        w_use_rd = 1'b1;
        w_jmp    = 1'b1;
        w_imm32  = {{12{idata[31]}}, idata[19:12], idata[20], idata[30:21], 1'b0};
      end
      OP_JALR: begin
        w_use_rs1 = 1'b1;
        w_use_rd  = 1'b1;
        w_jmp     = 1'b1;
        w_roi     = 1'b1;
        w_imm32   = {{20{idata[31]}}, idata[31:20]};
      end
      OP_BXX: begin
        w_use_rs1 = 1'b1;
        w_use_rs2 = 1'b1;
        w_br      = 1'b1;
        w_imm32   = {{20{idata[31]}}, idata[7], idata[30:25], idata[11:8], 1'b0};
        case (w_f3)
          3'd0, 3'd1: w_alu = ALUOP_W'(9);
          3'd4, 3'd5: w_alu = ALUOP_W'(2);
          3'd6, 3'd7: w_alu = ALUOP_W'(3);
          default:    w_alu = ALUOP_W'(15);
        endcase
      end
      OP_LXX: begin
        w_use_rs1 = 1'b1;
        w_use_rd  = 1'b1;
        w_m2r     = 1'b1;
        w_roi     = 1'b1;
        w_imm32   = {{20{idata[31]}}, idata[31:20]};
      end
      OP_SXX: begin
        w_use_rs1 = 1'b1;
        w_use_rs2 = 1'b1;
        w_mw      = 1'b1;
        w_roi     = 1'b1;
        w_imm32   = {{20{idata[31]}}, idata[31:25], idata[11:7]};
      end
      OP_IXX: begin
        w_use_rs1 = 1'b1;
        w_use_rd  = 1'b1;
        w_roi     = 1'b1;
        w_imm32   = {{20{idata[31]}}, idata[31:20]};
        w_alu     = (w_f3 == 3'd5 && idata[30]) ? ALUOP_W'(8) : ALUOP_W'(w_f3);
      end
      OP_RXX: begin
        w_use_rs1 = 1'b1;
        w_use_rs2 = 1'b1;
        w_use_rd  = 1'b1;
        if (idata[30] && w_f3 == 3'd0) begin
          w_alu = ALUOP_W'(9);
        end else if (idata[30] && w_f3 == 3'd5) begin
          w_alu = ALUOP_W'(8);
        end else begin
          w_alu = ALUOP_W'(w_f3);
        end
      end
      default: w_known = 1'b0;
    endcase
  end

  assign w_illegal  = ~w_known
                    | (w_use_rs1 & reg_oob(idata[19:15]))
                    | (w_use_rs2 & reg_oob(idata[24:20]))
                    | (w_use_rd  & reg_oob(idata[11:7]));
  assign w_regwrite = w_use_rd & ~w_illegal;
  assign w_rs1      = w_use_rs1 ? idata[15 +: RW] : '0;
  assign w_rs2      = w_use_rs2 ? idata[20 +: RW] : '0;
  assign w_rd       = w_use_rd  ? idata[7 +: RW]  : '0;

  // Out-of-range source fields are already trapped as illegal, so they never stall.
  assign w_pend   = {r_pend, 1'b0};
  assign w_hazard = (w_use_rs1 & ~reg_oob(idata[19:15]) & (w_rs1 != '0) & w_pend[w_rs1]
                     & ~(wbEn & (wbRd == w_rs1)))
                  | (w_use_rs2 & ~reg_oob(idata[24:20]) & (w_rs2 != '0) & w_pend[w_rs2]
                     & ~(wbEn & (wbRd == w_rs2)));

  assign iReady   = reset & ~flush & ~w_hazard & (~r_valid | dReady);
  assign w_accept = iValid & iReady;
  assign w_hs_out = r_valid & dReady;

  // Set is applied after both clears so a new writer keeps ownership; bit 0 is dropped.
  assign w_clr_wb   = wbEn ? (NREGS'(1) << wbRd) : '0;
  assign w_clr_fl   = (flush & r_valid & r_regwrite & ~w_hs_out) ? (NREGS'(1) << r_rd) : '0;
  assign w_set      = (w_accept & w_regwrite) ? (NREGS'(1) << w_rd) : '0;
  assign w_pend_nxt = (w_pend & ~w_clr_wb & ~w_clr_fl) | w_set;

  // Scoreboard and bundle-valid state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pend  <= '0;
      r_valid <= 1'b0;
    end else begin
      r_pend <= w_pend_nxt[NREGS-1:1];
      if (w_accept) begin
        r_valid <= 1'b1;
      end else if (flush | w_hs_out) begin
        r_valid <= 1'b0;
      end
    end
  end

  // Bundle registers: load on accept, otherwise hold.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pc       <= '0;
      r_imm      <= '0;
      r_alu      <= '0;
      r_f3       <= 3'd0;
      r_rs1      <= '0;
      r_rs2      <= '0;
      r_rd       <= '0;
      r_br       <= 1'b0;
      r_jmp      <= 1'b0;
      r_m2r      <= 1'b0;
      r_mw       <= 1'b0;
      r_roi      <= 1'b0;
      r_regwrite <= 1'b0;
      r_illegal  <= 1'b0;
    end else if (w_accept) begin
      r_pc       <= iPc;
      r_imm      <= XLEN'(signed'(w_imm32));
      r_alu      <= w_illegal ? '0 : w_alu;
      r_f3       <= w_f3;
      r_rs1      <= w_rs1;
      r_rs2      <= w_rs2;
      r_rd       <= w_rd;
      r_br       <= w_br  & ~w_illegal;
      r_jmp      <= w_jmp & ~w_illegal;
      r_m2r      <= w_m2r & ~w_illegal;
      r_mw       <= w_mw  & ~w_illegal;
      r_roi      <= w_roi;
      r_regwrite <= w_regwrite;
      r_illegal  <= w_illegal;
    end
  end

  assign dValid    = r_valid;
  assign dPc       = r_pc;
  assign imm       = r_imm;
  assign aluOp     = r_alu;
  assign funct3    = r_f3;
  assign rs1       = r_rs1;
  assign rs2       = r_rs2;
  assign rd        = r_rd;
  assign branch    = r_br;
  assign jump      = r_jmp;
  assign dMEMToReg = r_m2r;
  assign memWrite  = r_mw;
  assign regOrImm  = r_roi;
  assign regWrite  = r_regwrite;
  assign illegal   = r_illegal;
endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: an instruction-level model checked every cycle,
// plus literal expectations for the key scenarios and an NREGS=16 instance.
module tb_decode_stage;
  logic        clk = 1'b0;
  logic        reset, iValid, flush, wbEn, dReady;
  logic [31:0] idata, iPc;
  logic [4:0]  wbRd;

  logic        iReady, dValid, branch, jump, dMEMToReg, memWrite, regOrImm, regWrite, illegal;
  logic [31:0] dPc, imm;
  logic [5:0]  aluOp;
  logic [2:0]  funct3;
  logic [4:0]  rs1, rs2, rd;

  logic        q_iReady, q_dValid, q_branch, q_jump, q_m2r, q_memWrite, q_roi, q_regWrite, q_illegal;
  logic [31:0] q_dPc, q_imm;
  logic [5:0]  q_aluOp;
  logic [2:0]  q_funct3;
  logic [3:0]  q_rs1, q_rs2, q_rd;

  always #5 clk = ~clk;

  decode_stage #(.XLEN(32), .NREGS(32), .ALUOP_W(6)) u_dut (
    .clk(clk), .reset(reset), .iValid(iValid), .iReady(iReady), .idata(idata), .iPc(iPc),
    .flush(flush), .wbEn(wbEn), .wbRd(wbRd), .dValid(dValid), .dReady(dReady), .dPc(dPc),
    .imm(imm), .aluOp(aluOp), .funct3(funct3), .rs1(rs1), .rs2(rs2), .rd(rd),
    .branch(branch), .jump(jump), .dMEMToReg(dMEMToReg), .memWrite(memWrite),
    .regOrImm(regOrImm), .regWrite(regWrite), .illegal(illegal));

  decode_stage #(.XLEN(32), .NREGS(16), .ALUOP_W(6)) u_dut16 (
    .clk(clk), .reset(reset), .iValid(iValid), .iReady(q_iReady), .idata(idata), .iPc(iPc),
    .flush(flush), .wbEn(wbEn), .wbRd(wbRd[3:0]), .dValid(q_dValid), .dReady(dReady), .dPc(q_dPc),
    .imm(q_imm), .aluOp(q_aluOp), .funct3(q_funct3), .rs1(q_rs1), .rs2(q_rs2), .rd(q_rd),
    .branch(q_branch), .jump(q_jump), .dMEMToReg(q_m2r), .memWrite(q_memWrite),
    .regOrImm(q_roi), .regWrite(q_regWrite), .illegal(q_illegal));

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] imm;
    logic [5:0]  alu;
    logic [2:0]  f3;
    logic [4:0]  rs1, rs2, rd;
    logic        br, jmp, m2r, mw, roi, rw, ill;
  } bnd_t;

  int n_cmp = 0;
  int n_bad = 0;

  bnd_t        m_b;
  logic        m_valid;
  logic [31:0] m_pend;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Instruction semantics: sign arithmetic on the encoded immediate pieces.
  function automatic bnd_t decode(input logic [31:0] ins, input logic [31:0] pc);
    bnd_t b;
    int   sgn;
    logic [2:0] f3;
    b   = '0;
    b.pc = pc;
    f3  = ins[14:12];
    b.f3 = f3;
    sgn = ins[31] ? -1 : 0;
    case (ins[6:0])
      7'h37, 7'h17: begin
        b.rd = ins[11:7]; b.rw = 1'b1; b.roi = 1'b1; b.imm = ins & 32'hFFFF_F000;
      end
      7'h6F: begin
        b.rd = ins[11:7]; b.rw = 1'b1; b.jmp = 1'b1;
        b.imm = sgn * 1048576 + int'(ins[19:12]) * 4096 + int'(ins[20]) * 2048 + int'(ins[30:21]) * 2;
      end
      7'h67: begin
        b.rs1 = ins[19:15]; b.rd = ins[11:7]; b.rw = 1'b1; b.jmp = 1'b1; b.roi = 1'b1;
        b.imm = sgn * 4096 + int'(ins[31:20]);
      end
      7'h63: begin
        b.rs1 = ins[19:15]; b.rs2 = ins[24:20]; b.br = 1'b1;
        b.imm = sgn * 4096 + int'(ins[7]) * 2048 + int'(ins[30:25]) * 32 + int'(ins[11:8]) * 2;
        if (f3 <= 3'd1)                     b.alu = 6'd9;
        else if (f3 == 3'd4 || f3 == 3'd5) b.alu = 6'd2;
        else if (f3 >= 3'd6)               b.alu = 6'd3;
        else                                b.alu = 6'd15;
      end
      7'h03: begin
        b.rs1 = ins[19:15]; b.rd = ins[11:7]; b.rw = 1'b1; b.m2r = 1'b1; b.roi = 1'b1;
        b.imm = sgn * 4096 + int'(ins[31:20]);
      end
      7'h23: begin
        b.rs1 = ins[19:15]; b.rs2 = ins[24:20]; b.mw = 1'b1; b.roi = 1'b1;
        b.imm = sgn * 4096 + int'(ins[31:25]) * 32 + int'(ins[11:7]);
      end
      7'h13: begin
        b.rs1 = ins[19:15]; b.rd = ins[11:7]; b.rw = 1'b1; b.roi = 1'b1;
        b.imm = sgn * 4096 + int'(ins[31:20]);
        b.alu = (f3 == 3'd5 && ins[30]) ? 6'd8 : {3'd0, f3};
      end
      7'h33: begin
        b.rs1 = ins[19:15]; b.rs2 = ins[24:20]; b.rd = ins[11:7]; b.rw = 1'b1;
        if (ins[30] && f3 == 3'd0)      b.alu = 6'd9;
        else if (ins[30] && f3 == 3'd5) b.alu = 6'd8;
        else                            b.alu = {3'd0, f3};
      end
      default: b.ill = 1'b1;
    endcase
    return b;
  endfunction

  function automatic logic m_ready();
    bnd_t d;
    logic haz;
    d   = decode(idata, iPc);
    haz = (d.rs1 != 5'd0 && m_pend[d.rs1] && !(wbEn && wbRd == d.rs1)) ||
          (d.rs2 != 5'd0 && m_pend[d.rs2] && !(wbEn && wbRd == d.rs2));
    return reset && !flush && !haz && (!m_valid || dReady);
  endfunction

  // Compare on the falling edge, then advance the model with the inputs that the next rising edge will see.
  initial begin
    bnd_t        d;
    logic        acc, hs;
    logic [31:0] nxt;
    m_b = '0; m_valid = 1'b0; m_pend = 32'd0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        m_b = '0; m_valid = 1'b0; m_pend = 32'd0;
      end
      chk("dValid",    {31'd0, dValid},    {31'd0, m_valid});
      chk("iReady",    {31'd0, iReady},    {31'd0, m_ready()});
      chk("dPc",       dPc,                m_b.pc);
      chk("imm",       imm,                m_b.imm);
      chk("aluOp",     {26'd0, aluOp},     {26'd0, m_b.alu});
      chk("funct3",    {29'd0, funct3},    {29'd0, m_b.f3});
      chk("rs1",       {27'd0, rs1},       {27'd0, m_b.rs1});
      chk("rs2",       {27'd0, rs2},       {27'd0, m_b.rs2});
      chk("rd",        {27'd0, rd},        {27'd0, m_b.rd});
      chk("branch",    {31'd0, branch},    {31'd0, m_b.br});
      chk("jump",      {31'd0, jump},      {31'd0, m_b.jmp});
      chk("dMEMToReg", {31'd0, dMEMToReg}, {31'd0, m_b.m2r});
      chk("memWrite",  {31'd0, memWrite},  {31'd0, m_b.mw});
      chk("regOrImm",  {31'd0, regOrImm},  {31'd0, m_b.roi});
      chk("regWrite",  {31'd0, regWrite},  {31'd0, m_b.rw});
      chk("illegal",   {31'd0, illegal},   {31'd0, m_b.ill});
      if (reset) begin
        d   = decode(idata, iPc);
        acc = iValid && m_ready();
        hs  = m_valid && dReady;
        nxt = m_pend;
        if (wbEn) nxt[wbRd] = 1'b0;
        if (flush && m_valid && m_b.rw && !hs) nxt[m_b.rd] = 1'b0;
        if (acc && d.rw) nxt[d.rd] = 1'b1;
        nxt[0] = 1'b0;
        m_pend = nxt;
        if (acc) begin
          m_b = d; m_valid = 1'b1;
        end else if (flush || hs) begin
          m_valid = 1'b0;
        end
      end
    end
  end

  task automatic issue(input logic [31:0] ins, input logic [31:0] pc, input logic [4:0] wb);
    int n;
    n = 0;
    idata = ins; iPc = pc; iValid = 1'b1; wbEn = (wb != 5'd0); wbRd = wb;
    #1;
    while (!iReady && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk("issue_accept", {31'd0, iReady}, 32'd1);
    @(posedge clk); #1;
    iValid = 1'b0; wbEn = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b0; iValid = 1'b0; flush = 1'b0; wbEn = 1'b0; dReady = 1'b1;
    idata = 32'd0; iPc = 32'd0; wbRd = 5'd0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_dvalid", {31'd0, dValid}, 32'd0);
    chk("rst_iready", {31'd0, iReady}, 32'd0);
    chk("rst_imm",    imm,             32'd0);
    reset = 1'b1;

    // ADDI x5,x0,7 then asynchronous reset while the bundle is valid.
    issue(32'h0070_0293, 32'h0000_0100, 5'd0);
    chk("addi_dvalid", {31'd0, dValid},   32'd1);
    chk("addi_imm",    imm,               32'd7);
    chk("addi_rd",     {27'd0, rd},       32'd5);
    chk("addi_rw",     {31'd0, regWrite}, 32'd1);
    dReady = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    chk("async_dvalid", {31'd0, dValid}, 32'd0);
    chk("async_iready", {31'd0, iReady}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b1; dReady = 1'b1; idata = 32'h0052_8333; iValid = 1'b0;
    #1;
    chk("async_pend_clear", {31'd0, iReady}, 32'd1);

    // RAW stall on x5, released by a same-cycle writeback.
    issue(32'h0070_0293, 32'h0000_0200, 5'd0);
    idata = 32'h0052_8333; iPc = 32'h0000_0204; iValid = 1'b1;
    #1;
    chk("raw_stall", {31'd0, iReady}, 32'd0);
    @(posedge clk); #1;
    chk("raw_stall2", {31'd0, iReady}, 32'd0);
    wbEn = 1'b1; wbRd = 5'd5;
    #1;
    chk("wb_release", {31'd0, iReady}, 32'd1);
    @(posedge clk); #1;
    wbEn = 1'b0; iValid = 1'b0;
    chk("add_dvalid", {31'd0, dValid}, 32'd1);
    chk("add_alu",    {26'd0, aluOp},  32'd0);
    chk("add_rs1",    {27'd0, rs1},    32'd5);
    chk("add_rs2",    {27'd0, rs2},    32'd5);

    // BNE x1,x2,-4 (also retires x6).
    issue(32'hFE20_9EE3, 32'h0000_0208, 5'd6);
    chk("bne_branch", {31'd0, branch},   32'd1);
    chk("bne_alu",    {26'd0, aluOp},    32'd9);
    chk("bne_f3",     {29'd0, funct3},   32'd1);
    chk("bne_imm",    imm,               32'hFFFF_FFFC);
    chk("bne_rw",     {31'd0, regWrite}, 32'd0);

    // SUB x7,x1,x2 held for three cycles, then flushed.
    issue(32'h4020_83B3, 32'h0000_020C, 5'd0);
    dReady = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("hold_alu",    {26'd0, aluOp},  32'd9);
      chk("hold_dvalid", {31'd0, dValid}, 32'd1);
      chk("hold_pc",     dPc,             32'h0000_020C);
    end
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; dReady = 1'b1;
    chk("flush_dvalid", {31'd0, dValid}, 32'd0);
    idata = 32'h0073_84B3; iPc = 32'h0000_0210; iValid = 1'b1;
    #1;
    chk("flush_pend7", {31'd0, iReady}, 32'd1);
    @(posedge clk); #1;
    iValid = 1'b0;

    // Illegal opcode, then a register field out of range for the 16-register build.
    issue(32'h0000_007F, 32'h0000_0300, 5'd9);
    chk("ill_flag",   {31'd0, illegal},  32'd1);
    chk("ill_rw",     {31'd0, regWrite}, 32'd0);
    chk("ill_dvalid", {31'd0, dValid},   32'd1);
    issue(32'h0020_88B3, 32'h0000_0304, 5'd0);
    chk("x17_ill16",    {31'd0, q_illegal},  32'd1);
    chk("x17_rw16",     {31'd0, q_regWrite}, 32'd0);
    chk("x17_dvalid16", {31'd0, q_dValid},   32'd1);
    chk("x17_ill32",    {31'd0, illegal},    32'd0);

    // Writeback and a new writer of x8 in the same cycle: the set wins.
    issue(32'h0010_0413, 32'h0000_0308, 5'd17);
    issue(32'h0020_0413, 32'h0000_030C, 5'd8);
    idata = 32'h0004_0533; iPc = 32'h0000_0310; iValid = 1'b1;
    #1;
    chk("set_wins", {31'd0, iReady}, 32'd0);
    wbEn = 1'b1; wbRd = 5'd8;
    #1;
    chk("set_wins_release", {31'd0, iReady}, 32'd1);
    @(posedge clk); #1;
    iValid = 1'b0; wbEn = 1'b0;

    // Remaining immediate formats and the arithmetic-shift aluOp.
    issue(32'h1234_51B7, 32'h0000_0400, 5'd10);
    chk("lui_imm", imm, 32'h1234_5000);
    issue(32'h0021_A423, 32'h0000_0404, 5'd3);
    chk("sw_imm", imm, 32'd8);
    chk("sw_mw",  {31'd0, memWrite}, 32'd1);
    issue(32'hFFC1_A203, 32'h0000_0408, 5'd0);
    chk("lw_imm", imm, 32'hFFFF_FFFC);
    issue(32'h0100_00EF, 32'h0000_040C, 5'd4);
    chk("jal_imm", imm, 32'd16);
    issue(32'h4031_D593, 32'h0000_0410, 5'd1);
    chk("srai_alu", {26'd0, aluOp}, 32'd8);
    issue(32'hFFFF_F617, 32'h0000_0414, 5'd11);
    chk("auipc_imm", imm, 32'hFFFF_F000);

    repeat (3) @(posedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- Registered, handshaked RV32I instruction-decode stage between fetch and execute.
- Decodes the same opcode set and aluOp encoding as the existing combinational control decoder.
- Adds parametrised register count, XLEN-wide immediate generation, illegal-instruction flagging, a flush input, and a scoreboard that stalls on read-after-write hazards until the register is written back.

Parameters:
XLEN, 32, datapath width; immediates are sign-extended to XLEN.
NREGS, 32, architectural register count (32 or 16); RW = $clog2(NREGS).
ALUOP_W, 6, aluOp width.

Ports:
clk  input  1  clock; all state updates on the rising edge.
reset  input  1  asynchronous, active-low reset.
iValid  input  1  fetch presents idata/iPc.
iReady  output  1  stage accepts this cycle.
idata  input  32  instruction word.
iPc  input  XLEN  instruction address.
flush  input  1  squash the instruction held in this stage.
wbEn  input  1  writeback/kill pulse from the last stage.
wbRd  input  RW  register being written back or killed.
dValid  output  1  decoded bundle valid.
dReady  input  1  execute consumes the bundle.
dPc  output  XLEN  registered iPc.
imm  output  XLEN  sign-extended immediate.
aluOp  output  ALUOP_W  0 add, 1 sll, 2 slt, 3 sltu, 4 xor, 5 srl, 6 or, 7 and, 8 sra, 9 sub, 15 invalid-branch.
funct3  output  3  idata[14:12], for branch condition and load/store size.
rs1, rs2, rd  output  RW each  register addresses; 0 when unused.
branch, jump, dMEMToReg, memWrite, regOrImm, regWrite, illegal  output  1 each  decoded controls.

Behaviour:
- Reset (reset low, asynchronous): dValid=0, all scoreboard bits 0, every bundle output 0. Deassertion takes effect at the next clk edge.
- Decode per opcode matches the existing decoder:
  - LUI/AUIPC: aluOp 0, regOrImm=1.
  - JAL/JALR: jump=1.
  - BXX: branch=1; aluOp 9 for funct3 0/1, 2 for 4/5, 3 for 6/7, 15 otherwise.
  - LXX: dMEMToReg=1.
  - SXX: memWrite=1.
  - IXX/RXX: aluOp rules as before, including SRAI/SRA → 8 and SUB → 9 via idata[30].
- Immediate types:
  - I: LXX, JALR, IXX.
  - S: SXX.
  - B: BXX, bit 0 = 0.
  - U: LUI, AUIPC, low 12 bits zero.
  - J: JAL, bit 0 = 0.
  - None: RXX, imm = 0.
- illegal=1 when:
  - the opcode is outside the nine above, or
  - a used register field is ≥ NREGS (NREGS=16 case).
  - Effect: regWrite=0, branch=jump=memWrite=dMEMToReg=0, aluOp=0. The bundle is still passed downstream, for the trap.
- Usage: rs1 is used by every opcode except LUI, AUIPC, JAL. rs2 is used by BXX, SXX, RXX. Unused fields output 0.
- Scoreboard pend[NREGS-1:1]; pend[0] is hardwired 0.
- Hazard, per used source register s: s≠0 & pend[s] & ~(wbEn & wbRd==s). A same-cycle writeback clears the hazard combinationally.
- iReady = reset & ~flush & ~hazard & (~dValid | dReady). iReady does not depend on iValid.
- Accept = iValid & iReady. On accept, the bundle registers load and dValid=1 next cycle.
  - If regWrite & rd≠0 for the accepted instruction, pend[rd] is set.
  - Latency: exactly 1 cycle from accept to dValid.
- Hold: dValid & ~dReady freezes all bundle outputs.
- dValid & dReady without accept → dValid=0 next cycle.
- Writeback: wbEn clears pend[wbRd].
  - If wbEn and a set target the same register in the same cycle, the set wins (the new writer owns it).
  - wbRd=0 is ignored.
- Flush:
  - dValid=0 next cycle; no accept that cycle.
  - If the held bundle has regWrite & rd≠0 and is not handshaking out that cycle, its pend[rd] is cleared.
  - Instructions squashed beyond this stage must be drained by the downstream stage pulsing wbEn with their rd.
- Back-to-back: with dReady held high and no hazards, one instruction per cycle.

Test Plan:
- Reset low mid-stream with dValid=1, pend[5]=1 → dValid=0 and pend all 0 immediately, with no clk edge; iReady=0 while reset is low.
- ADDI x5,x0,7 (0x00700293) then ADD x6,x5,x5 (0x00528333), dReady=1 → ADDI bundle: imm=7, aluOp=0, rd=5. ADD is stalled (iReady=0) until wbEn=1, wbRd=5; it is accepted in that same wbEn cycle and appears the next cycle with aluOp=0, rs1=rs2=5.
- BNE x1,x2,-4 (0xFE209EE3) → branch=1, aluOp=9, funct3=1, imm=0xFFFFFFFC, regWrite=0, no pend bit set.
- dReady=0 for 3 cycles with SUB x7,x1,x2 held → outputs stable, aluOp=9. Then flush=1 → dValid=0 next cycle and pend[7] cleared.
- Opcode 0x0000007F → illegal=1, regWrite=0, dValid=1. With NREGS=16, ADD x17,x1,x2 → illegal=1.
- Same cycle: wbEn with wbRd=8, plus accept of ADDI x8 → pend[8] remains 1.
